// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares the single data-RAM port between the MEM stage and a debug master, one transaction in flight.
// Build option DM_ARB_RR_EN selects round-robin; otherwise MEM has priority with a starvation guard for debug.
module dm_port_arbiter #(
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_req,
    input  logic [3:0]  mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_grant,
    output logic        mem_rvalid,
    output logic [31:0] mem_rdata,
    input  logic        dbg_req,
    input  logic [3:0]  dbg_wen,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_grant,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    output logic        dm_en,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_wen,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     state;
    logic       owner_dbg;
    logic       is_load;
    logic [1:0] lat_cnt;
    logic       pick_dbg;
    logic       grant_any;

    if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
        $error("dm_port_arbiter: RD_LAT must be in 1..3");
    end

`ifdef DM_ARB_RR_EN
    logic rr_dbg;

    assign pick_dbg = dbg_req && (!mem_req || rr_dbg);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            rr_dbg <= 1'b0;
        else if (grant_any)
            rr_dbg <= !pick_dbg;
    end
`else
    localparam int SW = $clog2(STARVE_MAX + 2);

    logic [SW-1:0] starve;

    assign pick_dbg = dbg_req && (!mem_req || starve == SW'(STARVE_MAX));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            starve <= '0;
        else if (grant_any)
            starve <= (pick_dbg || !dbg_req) ? '0 : starve + 1'b1;
    end
`endif

    // Grants are gated by resetn so nothing is accepted while reset is held.
    assign grant_any  = resetn && state == IDLE && (mem_req || dbg_req);
    assign dbg_grant  = grant_any && pick_dbg;
    assign mem_grant  = grant_any && !pick_dbg;
    assign mem_rvalid = state == RESP && !owner_dbg;
    assign dbg_rvalid = state == RESP && owner_dbg;
    assign mem_rdata  = (mem_rvalid && is_load) ? dm_rdata : 32'h0;
    assign dbg_rdata  = (dbg_rvalid && is_load) ? dm_rdata : 32'h0;
    assign busy       = state != IDLE;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            owner_dbg <= 1'b0;
            is_load   <= 1'b0;
            lat_cnt   <= 2'd0;
            dm_en     <= 1'b0;
            dm_addr   <= 32'h0;
            dm_wen    <= 4'h0;
            dm_wdata  <= 32'h0;
        end else begin
            dm_en  <= 1'b0;
            dm_wen <= 4'h0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        state     <= ISSUE;
                        owner_dbg <= pick_dbg;
                        is_load   <= (pick_dbg ? dbg_wen : mem_wen) == 4'h0;
                        dm_en     <= 1'b1;
                        dm_addr   <= pick_dbg ? dbg_addr : mem_addr;
                        dm_wen    <= pick_dbg ? dbg_wen : mem_wen;
                        dm_wdata  <= pick_dbg ? dbg_wdata : mem_wdata;
                    end
                end
                ISSUE: begin
                    state   <= (is_load && RD_LAT > 1) ? WAIT : RESP;
                    lat_cnt <= 2'(RD_LAT - 2);
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - 2'd1;
                    if (lat_cnt == 2'd0)
                        state <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: randomized check of two arbiter instances (RD_LAT 1 and 3) against a transaction-schedule model.
module tb_dm_port_arbiter;
    localparam int SM = 4;

    logic clk = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 30)
                $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [31:0] seed(input int i);
        return (32'(i) * 32'h0101_0101) ^ 32'hA5C3_0F00;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] w);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (w[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    for (genvar k = 0; k < 2; k++) begin : gl
        localparam int LAT = k ? 3 : 1;
        logic        rn, done;
        logic        mreq, dreq, mgnt, dgnt, mrv, drv, den, bsy;
        logic [3:0]  mwen, dwen, dmwen;
        logic [31:0] maddr, mwd, mrd, daddr, dwd, drd, dmaddr, dmwd, dmrd;
        logic [31:0] ram [64];
        logic [31:0] pipe [3];

        dm_port_arbiter #(.RD_LAT(LAT), .STARVE_MAX(SM)) dut (
            .clk(clk), .resetn(rn),
            .mem_req(mreq), .mem_wen(mwen), .mem_addr(maddr), .mem_wdata(mwd),
            .mem_grant(mgnt), .mem_rvalid(mrv), .mem_rdata(mrd),
            .dbg_req(dreq), .dbg_wen(dwen), .dbg_addr(daddr), .dbg_wdata(dwd),
            .dbg_grant(dgnt), .dbg_rvalid(drv), .dbg_rdata(drd),
            .dm_en(den), .dm_addr(dmaddr), .dm_wen(dmwen), .dm_wdata(dmwd),
            .dm_rdata(dmrd), .busy(bsy)
        );

        // RAM with RD_LAT-deep read pipeline; unused slots carry a poison word.
        always @(posedge clk) begin
            if (!rn)
                for (int i = 0; i < 64; i++) ram[i] <= seed(i);
            else if (den)
                ram[dmaddr[7:2]] <= merge(ram[dmaddr[7:2]], dmwd, dmwen);
            pipe[0] <= den ? ram[dmaddr[7:2]] : 32'hDEAD_BEEF;
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        assign dmrd = pipe[LAT-1];

        initial begin : drive
            int          n, g, r, starve;
            logic        act, ld, own, mh, dh, rst_done, em, ed, en, rv;
            logic [31:0] a, d, da, dd;
            logic [3:0]  w;
            logic [31:0] ref_mem [64];
            done = 1'b0;
            n = 0; g = 0; starve = 0;
            act = 0; ld = 0; own = 0; mh = 0; dh = 0; rst_done = 0;
            a = 0; d = 0; da = 0; dd = 0; w = 0;
            rn = 1'b0;
            mreq = 1'b0; dreq = 1'b0; mwen = 0; dwen = 0; maddr = 0; daddr = 0; mwd = 0; dwd = 0;
            for (int it = 0; it < 400; it++) begin
                @(posedge clk);
                #1;
                n++;
                if (it < 3)
                    rn = 1'b0;
                else if (it >= 200 && !rst_done && act && n >= g + 2) begin
                    rn = 1'b0;
                    rst_done = 1'b1;
                end else
                    rn = 1'b1;
                if (!mh) begin
                    mreq  = it < 60 || $urandom_range(0, 9) < 6;
                    mwen  = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
                    maddr = $urandom & 32'hFFFF_FFFC;
                    mwd   = $urandom;
                end
                if (!dh) begin
                    dreq  = it < 60 || $urandom_range(0, 9) < 5;
                    dwen  = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
                    daddr = $urandom & 32'hFFFF_FFFC;
                    dwd   = $urandom;
                end
                @(negedge clk);
                if (!rn) begin
                    check("rst mem_grant", 32'(mgnt), 0);
                    check("rst dbg_grant", 32'(dgnt), 0);
                    check("rst mem_rvalid", 32'(mrv), 0);
                    check("rst dbg_rvalid", 32'(drv), 0);
                    check("rst mem_rdata", mrd, 0);
                    check("rst dbg_rdata", drd, 0);
                    check("rst dm_en", 32'(den), 0);
                    check("rst dm_addr", dmaddr, 0);
                    check("rst dm_wen", 32'(dmwen), 0);
                    check("rst dm_wdata", dmwd, 0);
                    check("rst busy", 32'(bsy), 0);
                    act = 0; starve = 0; da = 0; dd = 0; mh = 0; dh = 0;
                    for (int i = 0; i < 64; i++) ref_mem[i] = seed(i);
                end else begin
                    em = !act && mreq && !(dreq && starve == SM);
                    ed = !act && dreq && !em;
                    en = act && n == g + 1;
                    r  = g + 1 + (ld ? LAT : 1);
                    rv = act && n == r;
                    check("mem_grant", 32'(mgnt), 32'(em));
                    check("dbg_grant", 32'(dgnt), 32'(ed));
                    check("mem_rvalid", 32'(mrv), 32'(rv && !own));
                    check("dbg_rvalid", 32'(drv), 32'(rv && own));
                    check("mem_rdata", mrd, (rv && !own && ld) ? ref_mem[a[7:2]] : 32'h0);
                    check("dbg_rdata", drd, (rv && own && ld) ? ref_mem[a[7:2]] : 32'h0);
                    check("dm_en", 32'(den), 32'(en));
                    check("dm_wen", 32'(dmwen), en ? 32'(w) : 32'h0);
                    check("dm_addr", dmaddr, da);
                    check("dm_wdata", dmwd, dd);
                    check("busy", 32'(bsy), 32'(act));
                    if (en) ref_mem[a[7:2]] = merge(ref_mem[a[7:2]], d, w);
                    if (rv) act = 0;
                    if (em || ed) begin
                        act = 1; g = n; own = ed;
                        a = ed ? daddr : maddr;
                        w = ed ? dwen : mwen;
                        d = ed ? dwd : mwd;
                        ld = w == 4'h0;
                        da = a; dd = d;
                        starve = (ed || !dreq) ? 0 : starve + 1;
                    end
                    mh = mreq && !em;
                    dh = dreq && !ed;
                end
            end
            done = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 2000 && !(gl[0].done && gl[1].done); i++)
            @(posedge clk);
        check("finished", 32'(gl[0].done && gl[1].done), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
